// File: rtl/vga_timing_if.sv
// vga_timing_if
//   Raster timing bundle produced by vga_timing and consumed by the video path.
//   master: driven by the timing generator; slave: read by downstream logic.
//   Signals: running, hcount/vcount (CW bits), active, hsync, vsync,
//   line_start, frame_start.
interface vga_timing_if #(
    parameter int CW = 10
);
    logic          running;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;

    modport master (
        output running, hcount, vcount, active, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input running, hcount, vcount, active, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing
//   Qualifies the PLL lock indication and then generates VGA raster timing
//   (default 640x480@60) on the pixel clock. All timing is held idle until
//   lock has been stable for LOCK_DELAY consecutive cycles.
// Ports
//   clock   in   pixel clock
//   reset   in   synchronous, active-high reset
//   locked  in   PLL lock indication (pixel clock domain)
//   vid     out  raster timing bundle (vga_timing_if.master)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_WAIT | counting consecutive locked cycles, all outputs idle
// ST_RUN  | lock qualified, raster counters advancing
module vga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int LOCK_DELAY = 1024,
    parameter int CW         = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         locked,
    vga_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counter only has to reach LOCK_DELAY-1 before the transition fires.
    localparam int LCW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

    localparam logic [CW-1:0]  H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]  V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]  H_ACT_C   = CW'(H_ACTIVE);
    localparam logic [CW-1:0]  V_ACT_C   = CW'(V_ACTIVE);
    localparam logic [CW-1:0]  HS_START  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]  HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]  VS_START  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]  VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_DELAY - 1);

    typedef enum logic {ST_WAIT, ST_RUN} state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           running_q, running_d;
    logic [CW-1:0]  hcount_q, hcount_d;
    logic [CW-1:0]  vcount_q, vcount_d;
    logic           active_q, active_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;

    // Next raster position is computed first; every decoded output is then
    // derived from that next position so all registered outputs line up.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        running_d  = 1'b0;
        hcount_d   = '0;
        vcount_d   = '0;

        unique case (state_q)
            ST_WAIT: begin
                if (!locked) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_RUN;
                    lock_cnt_d = '0;
                    running_d  = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked) begin
                    // Abort immediately; re-entry restarts at (0,0).
                    state_d    = ST_WAIT;
                    lock_cnt_d = '0;
                end else begin
                    running_d = 1'b1;
                    if (hcount_q == H_LAST) begin
                        hcount_d = '0;
                        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
                    end else begin
                        hcount_d = hcount_q + 1'b1;
                        vcount_d = vcount_q;
                    end
                end
            end
            default: begin
                state_d    = ST_WAIT;
                lock_cnt_d = '0;
            end
        endcase

        active_d      = running_d && (hcount_d < H_ACT_C) && (vcount_d < V_ACT_C);
        hsync_d       = (running_d && (hcount_d >= HS_START) && (hcount_d < HS_END))
                        ? HS_POL : ~HS_POL;
        vsync_d       = (running_d && (vcount_d >= VS_START) && (vcount_d < VS_END))
                        ? VS_POL : ~VS_POL;
        line_start_d  = running_d && (hcount_d == '0);
        frame_start_d = running_d && (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            lock_cnt_q    <= '0;
            running_q     <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            running_q     <= running_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.running     = running_q;
    assign vid.hcount      = hcount_q;
    assign vid.vcount      = vcount_q;
    assign vid.active      = active_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
endmodule
